ahb_arbiter: RTL
================

# ahb_arbiter

Round-robin bus arbiter that shares one AHB address/data channel among `NUM_MASTERS` AHB master instances. It takes each master's bus request and lock, and watches the currently owned transfer (HTRANS, HBURST, HREADY). From these it drives the one-hot grant vector, the owner index used by the address/write-data muxes, and the master-lock indication to the slave side. Grant handover happens only on HREADY-high edges and never in the middle of a fixed-length burst or a locked sequence.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesting masters, range 2..16.
- `MIDX_W`, default 2: width of HMASTER; must equal ceil(log2(NUM_MASTERS)).

Ports:
- `HCLK`  in  1  bus clock. One clock; reset is asynchronous and active-high.
- `HRESET`  in  1  asynchronous, active-high reset.
- `HBUSREQ`  in  NUM_MASTERS  per-master bus request.
- `HLOCK`  in  NUM_MASTERS  per-master locked-sequence request. Only meaningful together with HBUSREQ.
- `HTRANS`  in  2  transfer type of the current owner, after the mux. IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HBURST`  in  3  burst type of the current owner, after the mux.
- `HREADY`  in  1  bus ready. A transfer is accepted on an edge with HREADY=1.
- `HGRANT`  out  NUM_MASTERS  one-hot grant.
- `HMASTER`  out  MIDX_W  index of the master owning the current address phase.
- `HMASTLOCK`  out  1  the current address phase belongs to a locked sequence.

## Operation
- Reset values:
  - HGRANT = 1 (master 0 is the default/park master).
  - HMASTER = 0, HMASTLOCK = 0.
  - State OPEN, beat counter 0, round-robin pointer 0.
- The state machine, counter, pointer and HGRANT advance only on edges with HREADY=1. With HREADY=0, everything holds.
- Burst length by HBURST:
  - 010/011 → 4 beats.
  - 100/101 → 8 beats.
  - 110/111 → 16 beats.
  - 000 → SINGLE.
  - 001 → INCR (undefined length).
- State OPEN:
  - Arbitrate. The winner is the first asserted HBUSREQ found searching from the pointer upward, wrapping modulo NUM_MASTERS.
  - HGRANT <= onehot(winner); pointer <= (winner+1) mod NUM_MASTERS.
  - If no request is asserted, HGRANT <= onehot(0) and the pointer is unchanged.
  - If HTRANS=NONSEQ for the owner, arbitration is suppressed on this edge and the state changes by burst type and lock:
    - HLOCK[HMASTER]=1 → LOCKED.
    - Fixed-length burst → BURST, with counter <= len−1.
    - INCR → INCR.
    - SINGLE → stay in OPEN.
- State BURST:
  - Grant is held.
  - On an accepted SEQ, the counter decrements. When it goes 1→0, the next state is OPEN.
  - BUSY does not decrement.
  - IDLE or NONSEQ mid-burst (early termination): counter cleared, next state OPEN. A NONSEQ is re-evaluated as in OPEN on the same edge.
- State INCR: grant is held while HBUSREQ[HMASTER]=1. When it drops, the next state is OPEN.
- State LOCKED:
  - Grant is held while HLOCK[HMASTER]=1.
  - Exit to OPEN on an edge with HLOCK[HMASTER]=0 and HTRANS ∈ {IDLE, NONSEQ}. A NONSEQ on that edge is handled as in OPEN.
- Fairness: a master that keeps requesting in OPEN loses priority to every other requester for one round.
- HMASTER <= index(HGRANT) on each HREADY edge. HMASTLOCK <= HLOCK[index(HGRANT)] & HBUSREQ[index(HGRANT)] on the same edge.

## Timing
- Idle bus, request at edge n (sampled): HGRANT changes at edge n, HMASTER follows at edge n+1, and the master's NONSEQ is seen from edge n+1. Latency is 1 cycle from grant to ownership.
- After the last SEQ of a fixed burst is accepted, arbitration occurs on the next HREADY edge. The new owner's first address phase comes one cycle later, which is one bubble. The current owner must drive IDLE during that cycle.
- The counter is 4 bits and saturates at 0. It never underflows.
- Simultaneous events:
  - A request arriving in the same cycle as an owner's NONSEQ waits for the state to return to OPEN.
  - Requests from multiple masters in the same cycle are resolved solely by the pointer.
- HREADY low during the final beat: the counter stays at 1 and the grant does not move.
- HRESET asserted mid-burst: all outputs return immediately (asynchronously) to their reset values.
- With no HREADY=1 edges, outputs never change.

## Test plan
- **Reset:** assert HRESET mid-run → HGRANT=0001, HMASTER=0, HMASTLOCK=0 within the same cycle; after release with no requests, HGRANT stays 0001.
- **Round-robin:** HBUSREQ=0110 held, SINGLE transfers only, HREADY=1 → grants alternate 0010, 0100, 0010, …; HMASTER lags HGRANT by one cycle.
- **Burst hold:** master 1 issues INCR4 (HBURST=011) while master 2 requests, with 2 wait states on beat 3 → HGRANT stays 0010 through all 4 accepted beats and moves to 0100 on the first HREADY edge after the last SEQ.
- **BUSY:** WRAP8 with two BUSY cycles inserted → grant held for exactly 8 accepted NONSEQ/SEQ beats.
- **INCR:** master 3 issues INCR and holds HBUSREQ for 10 cycles with master 0 requesting → grant moves only after HBUSREQ[3] drops.
- **Lock:** master 2 locked with HLOCK=1 over two INCR4 bursts → HMASTLOCK=1 for both bursts; no grant change until HLOCK=0 and HTRANS=IDLE.

Source files
------------

// File: rtl/ahb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_arbiter : round-robin AHB arbiter with burst/INCR/lock ownership hold   |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ahb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MIDX_W-1:0]      HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] c_st_open   = 2'd0;
  localparam logic [1:0] c_st_burst  = 2'd1;
  localparam logic [1:0] c_st_incr   = 2'd2;
  localparam logic [1:0] c_st_locked = 2'd3;

  localparam logic [1:0] c_tr_idle   = 2'b00;
  localparam logic [1:0] c_tr_busy   = 2'b01;
  localparam logic [1:0] c_tr_nonseq = 2'b10;
  localparam logic [1:0] c_tr_seq    = 2'b11;

  localparam logic [MIDX_W:0]      c_num       = (MIDX_W+1)'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] c_park_grant = NUM_MASTERS'(1);

  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic [MIDX_W-1:0]      r_ptr;

  logic [NUM_MASTERS-1:0] w_req_rot;
  logic                   w_any_req;
  logic [MIDX_W-1:0]      w_winner;
  logic [MIDX_W:0]        w_sum;
  logic [MIDX_W:0]        w_ptr_inc;
  logic [MIDX_W-1:0]      w_grant_idx;
  logic                   w_own_lock;
  logic                   w_own_req;
  logic [1:0]             w_ns_state;
  logic [3:0]             w_ns_cnt;
  logic                   w_arb;
  logic [1:0]             w_state_nxt;
  logic [3:0]             w_cnt_nxt;
  logic [MIDX_W-1:0]      w_ptr_nxt;
  logic [NUM_MASTERS-1:0] w_grant_nxt;

  assign w_own_lock = HLOCK[HMASTER];
  assign w_own_req  = HBUSREQ[HMASTER];

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    w_req_rot = NUM_MASTERS'({HBUSREQ, HBUSREQ} >> r_ptr);
    w_any_req = 1'b0;
    w_winner  = '0;
    w_sum     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_any_req = 1'b1;
        w_sum     = {1'b0, r_ptr} + (MIDX_W+1)'(i);
        if (w_sum >= c_num) begin
          w_sum = w_sum - c_num;
        end
        w_winner = w_sum[MIDX_W-1:0];
      end
    end
    w_ptr_inc = {1'b0, w_winner} + (MIDX_W+1)'(1);
    if (w_ptr_inc >= c_num) begin
      w_ptr_inc = '0;
    end
  end

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) begin
        w_grant_idx = MIDX_W'(i);
      end
    end
  end

  // Ownership mode entered when the owner starts a new transfer with NONSEQ.
  always_comb begin
    w_ns_state = c_st_open;
    w_ns_cnt   = 4'd0;
    if (w_own_lock) begin
      w_ns_state = c_st_locked;
    end else begin
      case (HBURST)
        3'b000:         w_ns_state = c_st_open;
        3'b001:         w_ns_state = c_st_incr;
        3'b010, 3'b011: begin w_ns_state = c_st_burst; w_ns_cnt = 4'd3;  end
        3'b100, 3'b101: begin w_ns_state = c_st_burst; w_ns_cnt = 4'd7;  end
        default:        begin w_ns_state = c_st_burst; w_ns_cnt = 4'd15; end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = HGRANT;
    w_arb       = 1'b0;
    case (r_state)
      c_st_open: begin
        if (HTRANS == c_tr_nonseq) begin
          w_state_nxt = w_ns_state;
          w_cnt_nxt   = w_ns_cnt;
        end else begin
          w_arb = 1'b1;
        end
      end
      c_st_burst: begin
        case (HTRANS)
          c_tr_seq: begin
            w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
              w_state_nxt = c_st_open;
            end
          end
          c_tr_nonseq: begin
            w_state_nxt = w_ns_state;
            w_cnt_nxt   = w_ns_cnt;
          end
          c_tr_idle: begin
            w_state_nxt = c_st_open;
            w_cnt_nxt   = 4'd0;
          end
          default: ;
        endcase
      end
      c_st_incr: begin
        if (!w_own_req) begin
          w_state_nxt = c_st_open;
        end
      end
      default: begin
        if (!w_own_lock) begin
          if (HTRANS == c_tr_idle) begin
            w_state_nxt = c_st_open;
          end else if (HTRANS == c_tr_nonseq) begin
            w_state_nxt = w_ns_state;
            w_cnt_nxt   = w_ns_cnt;
          end
        end
      end
    endcase
    if (w_arb) begin
      if (w_any_req) begin
        w_grant_nxt           = '0;
        w_grant_nxt[w_winner] = 1'b1;
        w_ptr_nxt             = w_ptr_inc[MIDX_W-1:0];
      end else begin
        w_grant_nxt = c_park_grant;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= c_st_open;
      r_cnt     <= 4'd0;
      r_ptr     <= '0;
      HGRANT    <= c_park_grant;
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      HGRANT    <= w_grant_nxt;
      HMASTER   <= w_grant_idx;
      HMASTLOCK <= HLOCK[w_grant_idx] & HBUSREQ[w_grant_idx];
    end
  end

endmodule
`default_nettype wire
